// File: rtl/btn_pkg.sv
// Shared types for the button event decoder: FSM state encoding and press counter width.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } btn_state_t;

    localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/hold_timer.sv
// Loadable/clearable saturating up-counter with a terminal-value compare, used to time
// both the long-press threshold and the auto-repeat interval.
module hold_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt;

    // Clear beats load beats increment; increment stops at all-ones so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_term = (cnt == term);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into registered single-cycle event pulses and a press count.
// Optional auto-repeat while long-held is enabled by defining BTN_AUTO_REPEAT_EN.
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4,
    parameter int CNT_W         = $clog2(LONG_CYCLES + REPEAT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_level,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic                   click_pulse,
    output logic                   long_pulse,
    output logic                   repeat_pulse,
    output logic                   held,
    output logic [PRESS_CNT_W-1:0] press_count
);

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);

    btn_state_t             state_q, state_d;
    logic                   press_d, release_d, click_d, long_d, repeat_d;
    logic [PRESS_CNT_W-1:0] count_d;
    logic                   hold_clr, hold_ld, hold_inc, hold_at_term;
    logic [CNT_W-1:0]       hold_term;

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_TERM = CNT_W'(REPEAT_CYCLES - 1);
    // The same counter times the repeat interval once the long press has been reached.
    assign hold_term = (state_q == LONG) ? REP_TERM : LONG_TERM;
`else
    assign hold_term = LONG_TERM;
`endif

    hold_timer #(.CNT_W(CNT_W)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .clr     (hold_clr),
        .ld      (hold_ld),
        .ld_val  (CNT_W'(1)),
        .inc     (hold_inc),
        .term    (hold_term),
        .at_term (hold_at_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= '0;
        end else begin
            state_q       <= state_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            click_pulse   <= click_d;
            long_pulse    <= long_d;
            repeat_pulse  <= repeat_d;
            held          <= (state_d != IDLE);
            press_count   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        count_d   = press_count;
        hold_clr  = 1'b0;
        hold_ld   = 1'b0;
        hold_inc  = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_level) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    count_d = press_count + 1'b1;
                    hold_ld = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_level) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                    hold_clr  = 1'b1;
                end else if (hold_at_term) begin
                    state_d = LONG;
                    long_d  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                    hold_clr = 1'b1;
`else
                    hold_inc = 1'b1;
`endif
                end else begin
                    hold_inc = 1'b1;
                end
            end
            LONG: begin
                if (!btn_level) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    hold_clr  = 1'b1;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (hold_at_term) begin
                        repeat_d = 1'b1;
                        hold_clr = 1'b1;
                    end else begin
                        hold_inc = 1'b1;
                    end
`else
                    hold_inc = 1'b1;
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                hold_clr = 1'b1;
            end
        endcase
    end

endmodule
